// File: rtl/nx_xrfb_pkg.sv
// Shared constants and types for the NX_XRFB register-file FIFO.
package nx_xrfb_pkg;

  // Default geometry matches one NX_XRFB_64x18 register file.
  localparam int NX_XRFB_WIDTH = 18;
  localparam int NX_XRFB_AW    = 6;

  // Pointer and occupancy types at the default geometry.
  typedef logic [NX_XRFB_AW-1:0] xrfb_ptr_t;
  typedef logic [NX_XRFB_AW:0]   xrfb_occ_t;

endpackage

// File: rtl/nx_xrfb_fifo_mem.sv
// Register-file storage: synchronous write port, asynchronous read port.
module nx_xrfb_fifo_mem
  import nx_xrfb_pkg::*;
#(
  parameter int WIDTH = NX_XRFB_WIDTH,
  parameter int AW    = NX_XRFB_AW
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [2**AW];

  // Write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Asynchronous read port.
  always_comb begin
    rdata = mem[raddr];
  end

endmodule

// File: rtl/nx_xrfb_fifo.sv
// First-word-fall-through FIFO on a register file, capacity DEPTH+1.
// Optional occupancy port COUNT is enabled by defining NX_XRFB_FIFO_COUNT_EN.
module nx_xrfb_fifo
  import nx_xrfb_pkg::*;
#(
  parameter int WIDTH = NX_XRFB_WIDTH,
  parameter int AW    = NX_XRFB_AW
) (
  input  logic             CK,
  input  logic             RN,
  input  logic [WIDTH-1:0] I,
  input  logic             WE,
  output logic             FULL,
  input  logic             RE,
  output logic [WIDTH-1:0] O,
  output logic             OV
`ifdef NX_XRFB_FIFO_COUNT_EN
  ,
  output logic [AW:0]      COUNT
`endif
);

  localparam logic [AW:0] FULL_OCC = {1'b1, {AW{1'b0}}};

  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      occ;
  logic [AW:0]      occ_next;
  logic             push;
  logic             pop;
  logic             load;
  logic             ov_next;
  logic [WIDTH-1:0] rdata;

  nx_xrfb_fifo_mem #(
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_mem (
    .clk   (CK),
    .we    (push),
    .waddr (wptr),
    .wdata (I),
    .raddr (rptr),
    .rdata (rdata)
  );

  // Handshake decode: load the output stage from storage when it is empty or being popped.
  always_comb begin
    push     = WE && !FULL;
    pop      = OV && RE;
    load     = (occ != '0) && (!OV || pop);
    ov_next  = load || (OV && !pop);
    occ_next = occ + (AW+1)'(push) - (AW+1)'(load);
  end

  // Pointers, occupancy and the registered full flag.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
      FULL <= 1'b0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (load) rptr <= rptr + AW'(1);
      occ  <= occ_next;
      FULL <= (occ_next == FULL_OCC);
    end
  end

  // Output stage: O holds its last value when it drains empty.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      O  <= '0;
      OV <= 1'b0;
    end else begin
      OV <= ov_next;
      if (load) O <= rdata;
    end
  end

`ifdef NX_XRFB_FIFO_COUNT_EN
  // Total words held: storage plus the output stage.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) COUNT <= '0;
    else     COUNT <= occ_next + (AW+1)'(ov_next);
  end
`endif

endmodule

// File: tb/tb_nx_xrfb_fifo.sv
// Randomized self-checking bench for nx_xrfb_fifo against a queue-based model.
module tb_nx_xrfb_fifo;

  localparam int WIDTH = 18;
  localparam int AW    = 6;
  localparam int DEPTH = 2**AW;

  logic             CK = 1'b0;
  logic             RN;
  logic [WIDTH-1:0] I;
  logic             WE;
  logic             RE;
  logic             FULL;
  logic [WIDTH-1:0] O;
  logic             OV;
`ifdef NX_XRFB_FIFO_COUNT_EN
  logic [AW:0]      COUNT;
`endif

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Reference model: storage as a queue plus the output stage.
  logic [WIDTH-1:0] sq[$];
  logic [WIDTH-1:0] m_o;
  logic             m_ov;

  nx_xrfb_fifo #(
    .WIDTH (WIDTH),
    .AW    (AW)
  ) dut (
    .CK    (CK),
    .RN    (RN),
    .I     (I),
    .WE    (WE),
    .FULL  (FULL),
    .RE    (RE),
    .O     (O),
    .OV    (OV)
`ifdef NX_XRFB_FIFO_COUNT_EN
    ,
    .COUNT (COUNT)
`endif
  );

  always #5 CK = ~CK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    sq.delete();
    m_o  = '0;
    m_ov = 1'b0;
  endtask

  task automatic model_edge();
    bit pop;
    bit push;
    pop  = m_ov && RE;
    push = WE && (sq.size() < DEPTH);
    if (sq.size() > 0 && (!m_ov || pop)) begin
      m_o  = sq.pop_front();
      m_ov = 1'b1;
    end else if (pop) begin
      m_ov = 1'b0;
    end
    if (push) sq.push_back(I);
  endtask

  task automatic compare_all();
    check("o", O, m_o);
    check("ov", OV, m_ov);
    check("full", FULL, sq.size() == DEPTH);
`ifdef NX_XRFB_FIFO_COUNT_EN
    check("count", COUNT, sq.size() + m_ov);
`endif
  endtask

  // One clock: model advances on the edge, DUT is sampled 1 time unit later.
  task automatic step();
    @(posedge CK);
    if (RN) model_edge();
    #1;
    compare_all();
  endtask

  initial begin
    RN = 1'b0; WE = 1'b0; RE = 1'b0; I = '0;
    model_reset();
    #3;
    check("rst_o", O, 0);
    check("rst_ov", OV, 0);
    check("rst_full", FULL, 0);
    step();
    step();
    RN = 1'b1;

    // Single word with consumer ready.
    WE = 1'b1; RE = 1'b1; I = 18'h00001;
    step();
    WE = 1'b0;
    step();
    check("single_ov1", OV, 1);
    check("single_o", O, 18'h00001);
    step();
    check("single_ov0", OV, 0);

    // Fill to capacity with the consumer stalled; the 66th word is dropped.
    RE = 1'b0;
    for (int i = 0; i < 66; i++) begin
      WE = 1'b1; I = WIDTH'(i);
      step();
      if (i == 64) check("full_at_65", FULL, 1);
    end
    WE = 1'b0;
    check("full_held", FULL, 1);
    RE = 1'b1;
    for (int i = 0; i < DEPTH + 4; i++) step();
    check("drained_ov", OV, 0);

    // Simultaneous push and pop while full: pop happens, push refused.
    RE = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      WE = 1'b1; I = WIDTH'(16'h100 + i);
      step();
    end
    check("refill_full", FULL, 1);
    WE = 1'b1; RE = 1'b1; I = 18'h2AAAA;
    step();
    check("full_cleared", FULL, 0);
    check("full_pop_ov", OV, 1);
    WE = 1'b0;
    for (int i = 0; i < DEPTH + 4; i++) step();

    // Continuous stream with random consumer, wrapping the pointers.
    for (int i = 0; i < 200; i++) begin
      WE = 1'b1; RE = 1'($urandom); I = WIDTH'(18'h1000 + i);
      step();
    end
    WE = 1'b0; RE = 1'b1;
    for (int i = 0; i < DEPTH + 4; i++) step();
    check("stream_empty", OV, 0);

    // Fully random traffic.
    for (int i = 0; i < 600; i++) begin
      WE = ($urandom_range(0, 3) != 0);
      RE = ($urandom_range(0, 2) == 0);
      I  = WIDTH'($urandom);
      step();
    end
    WE = 1'b0; RE = 1'b1;
    for (int i = 0; i < DEPTH + 4; i++) step();

    // Asynchronous reset with ten words queued.
    RE = 1'b0;
    for (int i = 0; i < 10; i++) begin
      WE = 1'b1; I = WIDTH'(18'h3F000 + i);
      step();
    end
    WE = 1'b0;
    #2;
    RN = 1'b0;
    model_reset();
    #1;
    check("arst_o", O, 0);
    check("arst_ov", OV, 0);
    check("arst_full", FULL, 0);
    step();
    RN = 1'b1;
    WE = 1'b1; I = 18'h3FFFF;
    step();
    WE = 1'b0; RE = 1'b1;
    step();
    check("post_rst_o", O, 18'h3FFFF);
    check("post_rst_ov", OV, 1);
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
